// File: rtl/parking_arb_pkg.sv
// Shared types and constants for the parking gate arbiter.
// The DENY state exists only when PARKING_ARB_DENY_EN is defined.
package parking_arb_pkg;

    localparam int   MAX_GATES = 8;
    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
`ifdef PARKING_ARB_DENY_EN
        , ST_DENY = 2'd3
`endif
    } state_t;

    // Exits always pass; entries need a free slot of the car's own type.
    function automatic logic is_eligible(input logic req, input logic dir, input logic uni,
                                         input logic uni_vac, input logic vac);
        return req && ((dir == DIR_EXIT) || (uni ? uni_vac : vac));
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set candidate at or after ptr,
// wrapping around.
module rr_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     candidates,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        valid   = 1'b0;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            pos     = (int'(ptr) + off) % N;
            pos_idx = IDX_W'(pos);
            if (candidates[pos_idx]) begin
                valid = 1'b1;
                index = pos_idx;
            end
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing the Parking counter's single event interface among gates.
// Optional feature: define PARKING_ARB_DENY_EN to refuse entries when the lot is full.
module parking_gate_arbiter
    import parking_arb_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_GATES-1:0] gate_req,
    input  logic [NUM_GATES-1:0] gate_dir,
    input  logic [NUM_GATES-1:0] gate_uni,
    output logic [NUM_GATES-1:0] gate_ack,
    output logic [NUM_GATES-1:0] gate_deny,
    input  logic                 uni_is_vacated_space,
    input  logic                 is_vacated_space,
    output logic                 car_entered,
    output logic                 is_uni_car_entered,
    output logic                 car_exited,
    output logic                 is_uni_car_exited,
    output logic                 busy
);

    localparam int               IDX_W       = $clog2(NUM_GATES);
    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       ptr, next_ptr, sel_idx, pick_idx;
    logic                   sel_dir, sel_uni, pick_valid;
    logic [CNT_W-1:0]       settle_cnt;
    logic [NUM_GATES-1:0]   eligible, candidates, sel_onehot;

    always_comb begin
        eligible = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            eligible[g] = is_eligible(gate_req[g], gate_dir[g], gate_uni[g],
                                      uni_is_vacated_space, is_vacated_space);
        end
    end

`ifdef PARKING_ARB_DENY_EN
    // Any request competes; a picked one that is not eligible is refused.
    assign candidates = gate_req;
`else
    // Entries blocked by a full lot stay pending until space frees.
    assign candidates = eligible;
`endif

    rr_picker #(.N(NUM_GATES)) u_picker (
        .candidates (candidates),
        .ptr        (ptr),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    assign next_ptr   = (sel_idx == IDX_W'(NUM_GATES - 1)) ? '0 : sel_idx + 1'b1;
    assign sel_onehot = NUM_GATES'(1) << sel_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
`ifdef PARKING_ARB_DENY_EN
                    state_nxt = eligible[pick_idx] ? ST_ISSUE : ST_DENY;
`else
                    state_nxt = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_IDLE;
`ifdef PARKING_ARB_DENY_EN
            ST_DENY:   state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Selection is latched in IDLE so requester changes cannot corrupt the issued event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            sel_idx    <= '0;
            sel_dir    <= DIR_ENTRY;
            sel_uni    <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        sel_idx <= pick_idx;
                        sel_dir <= gate_dir[pick_idx];
                        sel_uni <= gate_uni[pick_idx];
                    end
                end
                ST_ISSUE: begin
                    ptr        <= next_ptr;
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
`ifdef PARKING_ARB_DENY_EN
                ST_DENY: ptr <= next_ptr;
`endif
                default: ;
            endcase
        end
    end

    // Outputs decode only flops, so an asynchronous reset clears a pulse at once.
    always_comb begin
        gate_ack           = '0;
        gate_deny          = '0;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        car_exited         = 1'b0;
        is_uni_car_exited  = 1'b0;
        if (state == ST_ISSUE) begin
            gate_ack           = sel_onehot;
            car_entered        = (sel_dir == DIR_ENTRY);
            is_uni_car_entered = (sel_dir == DIR_ENTRY) && sel_uni;
            car_exited         = (sel_dir == DIR_EXIT);
            is_uni_car_exited  = (sel_dir == DIR_EXIT) && sel_uni;
        end
`ifdef PARKING_ARB_DENY_EN
        if (state == ST_DENY) gate_deny = sel_onehot;
`endif
    end

    assign busy = (state != ST_IDLE);

endmodule
